// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: fetch->execute pipeline register with full RV32I field
// extraction, immediate generation and legality checking.
// Optional build macro: RV32I_DECODE_SKID_EN selects a two-entry skid buffer
// (registered in_ready). When it is undefined, a single output register is used,
// and in_ready depends combinationally on out_ready.
module rv32i_decode_stage #(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [31:0]         in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_inst,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [11:0]         out_funct12,
  output logic [31:0]         out_imm,
  output logic                out_decode_error
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         inst;
    logic [31:0]         imm;
    logic                err;
  } beat_t;

  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic [11:0] dec_f12;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [31:0] dec_imm;
  logic        dec_err;
  beat_t       in_beat;

  beat_t main_q;
  logic  main_valid_q;
  logic  rdy_en_q;
  logic  in_fire;
  logic  out_fire;

  assign dec_f3  = in_inst[14:12];
  assign dec_f7  = in_inst[31:25];
  assign dec_f12 = in_inst[31:20];
  assign dec_rd  = in_inst[11:7];
  assign dec_rs1 = in_inst[19:15];

  // Immediate selection and RV32I legality check for the incoming instruction
  always_comb begin
    dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
    dec_err = 1'b0;
    case (opcode_e'(in_inst[6:0]))
      OPC_STORE: begin
        dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec_err = (dec_f3 > 3'd2);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_imm = {in_inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OPC_BRANCH: begin
        dec_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        dec_err = (dec_f3 == 3'd2) || (dec_f3 == 3'd3);
      end
      OPC_LOAD: begin
        dec_err = !((dec_f3 == 3'd0) || (dec_f3 == 3'd1) || (dec_f3 == 3'd2) ||
                    (dec_f3 == 3'd4) || (dec_f3 == 3'd5));
      end
      OPC_JALR: begin
        dec_err = (dec_f3 != 3'd0);
      end
      OPC_OP: begin
        dec_err = !((dec_f7 == 7'h00) ||
                    ((dec_f7 == 7'h20) && ((dec_f3 == 3'd0) || (dec_f3 == 3'd5))));
      end
      OPC_OP_IMM: begin
        if (dec_f3 == 3'd1) begin
          dec_err = (dec_f7 != 7'h00);
        end else if (dec_f3 == 3'd5) begin
          dec_err = !((dec_f7 == 7'h00) || (dec_f7 == 7'h20));
        end
      end
      OPC_SYSTEM: begin
        dec_err = (dec_f3 != 3'd0) ||
                  !((dec_f12 == 12'h000) || (dec_f12 == 12'h001)) ||
                  (dec_rd != 5'd0) || (dec_rs1 != 5'd0);
      end
      // Unknown opcodes, including any with inst[1:0] != 2'b11
      default: begin
        dec_err = 1'b1;
      end
    endcase
  end

  assign in_beat = '{pc: in_pc, inst: in_inst, imm: dec_imm, err: dec_err};

  // in_ready stays low through reset and goes high one cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

`ifdef RV32I_DECODE_SKID_EN
  beat_t skid_q;
  logic  skid_valid_q;

  // Only a full skid slot blocks upstream, so out_ready never reaches in_ready
  assign in_ready = rdy_en_q && !flush && !skid_valid_q;

  // Main register feeds the output; skid catches the beat accepted on the first
  // stall cycle and refills main before any newer beat can enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        if (in_fire) begin
          main_q <= in_beat;
        end
        main_valid_q <= in_fire;
      end
    end else if (in_fire) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = rdy_en_q && !flush && (!main_valid_q || out_ready);

  // Single output register, refilled whenever it is empty or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (in_fire) begin
        main_q <= in_beat;
      end
      main_valid_q <= in_fire;
    end
  end
`endif

  assign out_valid        = main_valid_q;
  assign out_pc           = main_q.pc;
  assign out_inst         = main_q.inst;
  assign out_opcode       = main_q.inst[6:0];
  assign out_rd           = main_q.inst[11:7];
  assign out_rs1          = main_q.inst[19:15];
  assign out_rs2          = main_q.inst[24:20];
  assign out_funct3       = main_q.inst[14:12];
  assign out_funct7       = main_q.inst[31:25];
  assign out_funct12      = main_q.inst[31:20];
  assign out_imm          = main_q.imm;
  assign out_decode_error = main_q.err;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: directed decode table, reset,
// backpressure and flush sequences, then randomized traffic against a queue
// scoreboard fed by a reference decoder written from the RV32I encoding rules.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [11:0] out_funct12;
  logic [31:0] out_imm;
  logic        out_decode_error;

  int unsigned tests = 0;
  int unsigned fails = 0;

  rv32i_decode_stage #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_funct12(out_funct12),
    .out_imm(out_imm), .out_decode_error(out_decode_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: immediates rebuilt by weighting each field by its bit
  // position, then sign-extended numerically.
  function automatic logic [31:0] sext(input longint unsigned v, input int nbits);
    longint unsigned r;
    r = v;
    if (v >= (64'd1 << (nbits - 1))) r = v - (64'd1 << nbits);
    return r[31:0];
  endfunction

  function automatic void ref_decode(input logic [31:0] x, output logic [31:0] imm,
                                     output logic err);
    int unsigned op, f3, f7, f12, rd, rs1;
    logic legal;
    op = x[6:0]; f3 = x[14:12]; f7 = x[31:25]; f12 = x[31:20];
    rd = x[11:7]; rs1 = x[19:15];
    case (op)
      'h23: imm = sext(longint'(x[31:25]) * 32 + longint'(x[11:7]), 12);
      'h37, 'h17: imm = x & 32'hFFFF_F000;
      'h6F: imm = sext(longint'(x[31]) * (1 << 20) + longint'(x[19:12]) * 4096 +
                       longint'(x[20]) * 2048 + longint'(x[30:21]) * 2, 21);
      'h63: imm = sext(longint'(x[31]) * 4096 + longint'(x[7]) * 2048 +
                       longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2, 13);
      default: imm = sext(longint'(x[31:20]), 12);
    endcase
    case (op)
      'h33: legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      'h13: legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1;
      'h03: legal = (f3 inside {0, 1, 2, 4, 5});
      'h23: legal = (f3 <= 2);
      'h63: legal = !(f3 inside {2, 3});
      'h67: legal = (f3 == 0);
      'h73: legal = (f3 == 0) && (f12 == 0 || f12 == 1) && (rd == 0) && (rs1 == 0);
      'h37, 'h17, 'h6F: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    err = !legal;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  logic stall_prev = 1'b0;
  exp_t snap;

  // Scoreboard: every accepted beat must leave exactly once, in order, decoded
  // as the reference says; a stalled beat must not change.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pc", out_pc, snap.pc);
        check("hold_inst", out_inst, snap.inst);
        check("hold_imm", out_imm, snap.imm);
        check("hold_err", 32'(out_decode_error), 32'(snap.err));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("sb_pc", out_pc, e.pc);
          check("sb_inst", out_inst, e.inst);
          check("sb_imm", out_imm, e.imm);
          check("sb_err", 32'(out_decode_error), 32'(e.err));
          check("sb_rd", 32'(out_rd), 32'(e.inst[11:7]));
          check("sb_rs2", 32'(out_rs2), 32'(e.inst[24:20]));
        end
      end
      if (in_valid && in_ready) begin
        e.pc = in_pc;
        e.inst = in_inst;
        ref_decode(in_inst, e.imm, e.err);
        sbq.push_back(e);
      end
      if (flush) begin
        check("flush_in_ready", 32'(in_ready), 32'd0);
        sbq.delete();
      end
      stall_prev = out_valid && !out_ready && !flush;
      snap.pc = out_pc;
      snap.inst = out_inst;
      snap.imm = out_imm;
      snap.err = out_decode_error;
    end
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[29];

  function automatic logic [31:0] gen_inst();
    logic [31:0] x;
    logic [6:0] ops[12];
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0F, 7'h00};
    x = $urandom;
    x[6:0] = ops[$urandom_range(0, 11)];
    if (x[6:0] == 7'h00) x[6:0] = 7'($urandom);
    if ($urandom_range(0, 1) == 1) x[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
    if (x[6:0] == 7'h73 && $urandom_range(0, 2) != 0) begin
      x[31:20] = 12'($urandom_range(0, 2));
      x[19:15] = '0;
      x[11:7] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      x[14:12] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
    end
    return x;
  endfunction

  initial begin
    logic [31:0] v;
    int unsigned sent, got, k;

    vecs[0]  = '{32'h00500093, 32'h00000005, 1'b0};
    vecs[1]  = '{32'h12345137, 32'h12345000, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{32'h00002073, 32'h00000000, 1'b1};
    vecs[5]  = '{32'h0200D093, 32'h00000020, 1'b1};
    vecs[6]  = '{32'h4020D093, 32'h00000402, 1'b0};
    vecs[7]  = '{32'h00000073, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h00100073, 32'h00000001, 1'b0};
    vecs[9]  = '{32'h00112623, 32'h0000000C, 1'b0};
    vecs[10] = '{32'h00003083, 32'h00000000, 1'b1};
    vecs[11] = '{32'h40000033, 32'h00000400, 1'b0};
    vecs[12] = '{32'h40001033, 32'h00000400, 1'b1};
    vecs[13] = '{32'h008000EF, 32'h00000008, 1'b0};
    vecs[14] = '{32'h00002063, 32'h00000000, 1'b1};
    vecs[15] = '{32'h00001067, 32'h00000000, 1'b1};
    vecs[16] = '{32'hFFFFF517, 32'hFFFFF000, 1'b0};
    vecs[17] = '{32'h00200073, 32'h00000002, 1'b1};
    vecs[18] = '{32'h00100173, 32'h00000001, 1'b1};
    vecs[19] = '{32'h00008073, 32'h00000000, 1'b1};
    vecs[20] = '{32'hFFF0C093, 32'hFFFFFFFF, 1'b0};
    vecs[21] = '{32'h02001013, 32'h00000020, 1'b1};
    vecs[22] = '{32'h0000000F, 32'h00000000, 1'b1};
    vecs[23] = '{32'h00000032, 32'h00000000, 1'b1};
    vecs[24] = '{32'h00004003, 32'h00000000, 1'b0};
    vecs[25] = '{32'h00006003, 32'h00000000, 1'b1};
    vecs[26] = '{32'h00003023, 32'h00000000, 1'b1};
    vecs[27] = '{32'hFE112E23, 32'hFFFFFFFC, 1'b0};
    vecs[28] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Decode table, one beat at a time
    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i); in_inst = vecs[i].inst; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      v = vecs[i].inst;
      check("tbl_out_valid", 32'(out_valid), 32'd1);
      check("tbl_pc", out_pc, 32'h100 + 32'(4 * i));
      check("tbl_imm", out_imm, vecs[i].imm);
      check("tbl_err", 32'(out_decode_error), 32'(vecs[i].err));
      check("tbl_opcode", 32'(out_opcode), 32'(v[6:0]));
      check("tbl_rd", 32'(out_rd), 32'(v[11:7]));
      check("tbl_rs1", 32'(out_rs1), 32'(v[19:15]));
      check("tbl_funct3", 32'(out_funct3), 32'(v[14:12]));
      check("tbl_funct7", 32'(out_funct7), 32'(v[31:25]));
      check("tbl_funct12", 32'(out_funct12), 32'(v[31:20]));
    end
    @(posedge clk); #1;

    // Reset mid-stream: outputs clear immediately, nothing emerges afterwards
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h200; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_imm", out_imm, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_no_beat", 32'(out_valid), 32'd0);
    end

    // Backpressure: four back-to-back beats, out_ready low in cycles 2..4
    sent = 0; got = 0; k = 0;
    while (got < 4 && k < 25) begin
      @(posedge clk); #1;
      out_ready = !(k >= 2 && k <= 4);
      in_valid = (sent < 4);
      in_inst = vecs[sent % 29].inst;
      in_pc = 32'h300 + 32'(4 * sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got++;
`ifdef RV32I_DECODE_SKID_EN
      if (k == 2) check("bp_accepted_by_c2", sent, 32'd3);
`else
      if (k == 2) check("bp_accepted_by_c2", sent, 32'd2);
`endif
      if (k == 3) check("bp_in_ready_c3", 32'(in_ready), 32'd0);
      k++;
    end
    check("bp_delivered", got, 32'd4);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Flush with held beats and a same-cycle input beat
    #1 out_ready = 1'b0;
    sent = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = vecs[i + 3].inst; in_pc = 32'h400 + 32'(4 * i);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
`ifdef RV32I_DECODE_SKID_EN
    check("flush_held_beats", sent, 32'd2);
`else
    check("flush_held_beats", sent, 32'd1);
`endif
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093;
    @(negedge clk);
    check("flush_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_flush_out_valid", 32'(out_valid), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_inst = gen_inst();
      in_pc = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
